// File: rtl/decoder_req_sched_pkg.sv
// -----------------------------------------------------------------------------
// decoder_req_sched_pkg
// Shared types and constants for the decoder request scheduler:
//   - default code/result widths of the shared decoder core
//   - scheduler state encoding (enum for readability, plain localparams for
//     the state register)
//   - width helper that never returns a zero-width vector
// -----------------------------------------------------------------------------
package decoder_req_sched_pkg;

    localparam int CODE_W_DEF = 7;
    localparam int OUT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Bits needed to index n values, with a floor of one bit.
    function automatic int width_min1(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/decoder_req_sched_if.sv
// -----------------------------------------------------------------------------
// decoder_req_sched_if
// Bundles the requester channels, the shared decoder port and the tagged
// response channel of the scheduler.
//   req_valid/req_code/req_ready : per-requester request handshake
//   dec_in/dec_out               : shared decoder input code / result
//   rsp_valid/rsp_ready/rsp_id/rsp_data : response channel
//   busy                         : scheduler not idle
// modport slave  : the scheduler
// modport master : requesters, decoder core and response consumer
// -----------------------------------------------------------------------------
interface decoder_req_sched_if
    import decoder_req_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CODE_W  = CODE_W_DEF,
    parameter int OUT_W   = OUT_W_DEF
) ();
    localparam int ID_W = width_min1(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*CODE_W-1:0] req_code;
    logic [NUM_REQ-1:0]        req_ready;
    logic [CODE_W-1:0]         dec_in;
    logic [OUT_W-1:0]          dec_out;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [OUT_W-1:0]          rsp_data;
    logic                      busy;

    modport slave (
        input  req_valid, req_code, dec_out, rsp_ready,
        output req_ready, dec_in, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_code, dec_out, rsp_ready,
        input  req_ready, dec_in, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/decoder_req_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_req_sched_rr_arbiter
// Combinational round-robin pick: first set request bit at or after the
// pointer, wrapping past NUM_REQ-1 back to 0.
//   i_req       : request vector
//   i_ptr       : highest-priority index (always < NUM_REQ)
//   o_grant_oh  : one-hot grant (zero when no request)
//   o_grant_idx : binary grant index (zero when no request)
//   o_any_valid : at least one request present
// -----------------------------------------------------------------------------
module decoder_req_sched_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_any_valid
);
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [ID_W-1:0]      w_off;
    logic [ID_W:0]        w_sum;

    // Rotate the request vector so the pointer position lands at bit 0.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    // Lowest set bit of the rotated vector is the distance from the pointer.
    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = ID_W'(k);
            end else begin
                w_off = w_off;
            end
        end
    end

    // Undo the rotation: pointer + distance, modulo NUM_REQ.
    always_comb begin
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
        end else begin
            w_sum = w_sum;
        end
    end

    // Drive grant outputs only when someone is asking.
    always_comb begin
        o_any_valid = |i_req;
        if (o_any_valid) begin
            o_grant_idx = w_sum[ID_W-1:0];
            o_grant_oh  = NUM_REQ'(1) << w_sum[ID_W-1:0];
        end else begin
            o_grant_idx = '0;
            o_grant_oh  = '0;
        end
    end
endmodule

// File: rtl/decoder_req_sched.sv
// -----------------------------------------------------------------------------
// decoder_req_sched
// Time-shares one decoder core among NUM_REQ requesters. A round-robin grant
// accepts one request from IDLE, the code is held on dec_in while a counter
// covers the DEC_LAT decoder latency, then the captured result is offered on
// the response channel (tagged with the requester index) until consumed.
//   clock : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : decoder_req_sched_if.slave (requests, decoder port, response, busy)
// Accept in cycle t gives rsp_valid first high in cycle t+2+DEC_LAT.
// -----------------------------------------------------------------------------
module decoder_req_sched
    import decoder_req_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CODE_W  = CODE_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int DEC_LAT = 2
) (
    input  logic                clock,
    input  logic                rst_n,
    decoder_req_sched_if.slave  bus
);
    localparam int              ID_W     = width_min1(NUM_REQ);
    localparam int              CNT_W    = width_min1(DEC_LAT + 1);
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(DEC_LAT);

    logic [1:0]          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [CODE_W-1:0]   r_dec_in;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [OUT_W-1:0]    r_rsp_data;

    logic [NUM_REQ-1:0]  w_grant_oh;
    logic [ID_W-1:0]     w_grant_idx;
    logic                w_any_valid;
    logic                w_accept;
    logic [CODE_W-1:0]   w_grant_code;
    logic [ID_W-1:0]     w_ptr_next;

    decoder_req_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req       (bus.req_valid),
        .i_ptr       (r_ptr),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_any_valid (w_any_valid)
    );

    // Accept pulse: only from IDLE, and held low while reset is asserted.
    always_comb begin
        if ((r_state == ST_IDLE) && w_any_valid && rst_n) begin
            w_accept      = 1'b1;
            bus.req_ready = w_grant_oh;
        end else begin
            w_accept      = 1'b0;
            bus.req_ready = '0;
        end
    end

    // AND-OR select of the granted requester's code.
    always_comb begin
        w_grant_code = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant_code = w_grant_code |
                (bus.req_code[i*CODE_W +: CODE_W] & {CODE_W{w_grant_oh[i]}});
        end
    end

    // Pointer moves just past the requester that was served, wrapping at the end.
    always_comb begin
        if (r_rsp_id == LAST_ID) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = r_rsp_id + ID_W'(1);
        end
    end

    // Scheduler FSM, latency counter, round-robin pointer and output registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_dec_in    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_dec_in <= w_grant_code;
                        r_rsp_id <= w_grant_idx;
                        r_cnt    <= LAT_LOAD;
                        r_state  <= ST_WAIT;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // dec_out is valid once the counter has run down.
                    if (r_cnt == '0) begin
                        r_rsp_data  <= bus.dec_out;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt       <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // rsp_valid is always high here, so rsp_ready alone completes it.
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_RESP;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dec_in    = r_dec_in;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = (r_state != ST_IDLE);
endmodule
